uart_rx_fifo: RTL and testbench
===============================

// Module: uart_rx_fifo
// PURPOSE
//  Serial UART receiver (8N1, LSB first) with a byte FIFO on the read side.
//  Oversamples the asynchronous rx line with the system clock and deframes
//  characters. Valid bytes are pushed into an internal FIFO, which the host
//  drains with rd_en. Sits between the external RX pin and the host data path.
// PARAMETERS
//  CLKS_PER_BIT  16  system clocks per UART bit period (must be >= 4, even)
//  FIFO_DEPTH    16  FIFO entries (power of 2, >= 2)
// PORTS
//  clk       in   1  system clock, all logic on posedge
//  reset     in   1  asynchronous, active-low reset
//  rx        in   1  serial input, idle high, asynchronous to clk
//  rd_en     in   1  pop request; ignored while rx_empty=1
//  rx_empty  out  1  1 = FIFO holds no bytes
//  d_out     out  8  byte popped by the last accepted rd_en
// BEHAVIOUR
//  Reset (reset=0, async): rx_empty=1, d_out=8'h00, FIFO pointers/count=0,
//   FSM=IDLE, bit counters=0, synchronizer flops=1. A frame in flight aborts.
//  rx passes through a 2-flop synchronizer (rx_s). All decisions use rx_s.
//  FSM states:
//   IDLE:  rx_s==0 -> START, timer cleared.
//   START: wait CLKS_PER_BIT/2 clocks, then resample. rx_s==1 is a false
//          start: go to IDLE. Otherwise go to DATA, timer cleared.
//   DATA:  sample rx_s every CLKS_PER_BIT clocks (mid-bit). Shift into bit
//          0..7 (LSB first). After the 8th sample go to STOP.
//   STOP:  sample after CLKS_PER_BIT clocks, then go to PUSH.
//   PUSH:  one cycle. Write the byte per the framing rule (CONFIGURATION),
//          then go to IDLE. The next start bit can be detected from then on.
//  FIFO write: occurs in the PUSH cycle. rx_empty falls on the next edge.
//   Full FIFO with no pop in the same cycle: the new byte is dropped and
//   the contents are unchanged.
//   Full FIFO with a pop in the same cycle: both the pop and the write occur.
//  FIFO read: rd_en=1 && rx_empty=0 at a posedge -> d_out is loaded with the
//   oldest byte at that edge (1-cycle latency), and the read pointer advances.
//   d_out holds its value otherwise. rd_en while empty changes nothing.
//  Simultaneous push and pop on a non-empty FIFO: count unchanged.
//   On an empty FIFO, a same-cycle rd_en is ignored and the push proceeds.
//  rx_empty is registered and equals (count==0) after each edge.
//  Pointers wrap modulo FIFO_DEPTH. count is $clog2(FIFO_DEPTH)+1 bits wide.
// CONFIGURATION
//  UART_RX_FRAMING_CHECK_EN defined: a byte whose stop sample is 0 is a
//   framing error and is discarded (no FIFO write). The FSM still returns
//   to IDLE.
//  Not defined: every completed frame is written regardless of the stop bit.
// TESTING
//  (CLKS_PER_BIT=16, FIFO_DEPTH=16, bit period = 16 clk)
//  1) Reset low mid-frame, then released -> rx_empty=1, d_out=00; the
//     partial byte never appears in the FIFO.
//  2) Send 8'hA5 (start=0, 1,0,1,0,0,1,0,1, stop=1) -> rx_empty falls about
//     9.5 bit times after the start edge. One rd_en pulse -> d_out=A5 the
//     next cycle, rx_empty=1.
//  3) Send 01, 02, ... 11 (17 bytes) with no reads -> 16 pops return
//     01..10 in order; 8'h11 was dropped; a 17th rd_en leaves d_out=10.
//  4) 0-pulse on rx of 4 clk -> no byte written, rx_empty stays 1.
//  5) Send 8'h3C with stop=0 -> with UART_RX_FRAMING_CHECK_EN: rx_empty
//     stays 1; without it: pop returns 3C. A following good 8'h7E is
//     received correctly in both builds.
//  6) FIFO holds 1 byte and rd_en coincides with the PUSH of 8'h55 ->
//     rx_empty stays 0; the next pop returns 55.

Source files
------------

// File: rtl/uart_rx_fifo_if.sv
// Host-side bundle of the UART receiver: serial line in, byte FIFO read port out.
// rd_en is a pop request; it is accepted only on a posedge where rx_empty is 0,
// and d_out then carries the popped byte from the following cycle onward.
interface uart_rx_fifo_if;
    logic       rx;
    logic       rd_en;
    logic       rx_empty;
    logic [7:0] d_out;

    modport master (output rx, output rd_en, input rx_empty, input d_out);
    modport slave  (input rx, input rd_en, output rx_empty, output d_out);
endinterface

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO. Define UART_RX_FRAMING_CHECK_EN to
// discard frames whose stop sample is 0; otherwise every completed frame is kept.
module uart_rx_fifo #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic          clk,
    input  logic          reset,
    uart_rx_fifo_if.slave bus,
    output logic [2:0]    fsm_state
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [TW-1:0] BIT_LAST  = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] HALF_LAST = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    // Encoding is visible on fsm_state: IDLE=0 START=1 DATA=2 STOP=3 PUSH=4.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        PUSH  = 3'd4
    } state_t;

    state_t        state, state_next;
    logic          rx_meta, rx_s;
    logic [TW-1:0] timer;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          frame_ok;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count, count_next;
    logic          pop, do_write;

    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (!rx_s) state_next = START;
            START: if (timer == HALF_LAST) state_next = rx_s ? IDLE : DATA;
            DATA:  if (timer == BIT_LAST && bit_cnt == 3'd7) state_next = STOP;
            STOP:  if (timer == BIT_LAST) state_next = PUSH;
            PUSH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Bit timer and shift register; the timer restarts at every sampling point.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            timer   <= '0;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                START, DATA, STOP: begin
                    if ((state == START && timer == HALF_LAST) ||
                        (state != START && timer == BIT_LAST)) timer <= '0;
                    else timer <= timer + 1'b1;
                    if (state == DATA && timer == BIT_LAST) begin
                        shreg   <= {rx_s, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                default: begin
                    timer   <= '0;
                    bit_cnt <= '0;
                end
            endcase
        end
    end

`ifdef UART_RX_FRAMING_CHECK_EN
    logic stop_bit;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                                stop_bit <= 1'b1;
        else if (state == STOP && timer == BIT_LAST) stop_bit <= rx_s;
    end
    assign frame_ok = stop_bit;
`else
    assign frame_ok = 1'b1;
`endif

    // A full FIFO still accepts a push when a pop frees a slot on the same edge.
    assign pop      = bus.rd_en && !bus.rx_empty;
    assign do_write = (state == PUSH) && frame_ok && ((count != FULL_CNT) || pop);

    always_comb begin
        count_next = count;
        if (do_write && !pop)      count_next = count + 1'b1;
        else if (!do_write && pop) count_next = count - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (do_write) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            bus.rx_empty <= 1'b1;
            bus.d_out    <= 8'h00;
        end else begin
            count        <= count_next;
            bus.rx_empty <= (count_next == '0);
            if (do_write) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                bus.d_out <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: table of frames plus hand-written
// sequences for overflow, glitch, reset mid-frame and coincident push/pop.
module tb_uart_rx_fifo;
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_PUSH = 3'd4;
`ifdef UART_RX_FRAMING_CHECK_EN
    localparam logic BAD_STOP_KEPT = 1'b0;
`else
    localparam logic BAD_STOP_KEPT = 1'b1;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] fsm_state;
    int         vectors = 0;
    int         miscompares = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       stored;
    } vec_t;
    vec_t vecs[10];

    uart_rx_fifo_if bus ();

    uart_rx_fifo #(.CLKS_PER_BIT(16), .FIFO_DEPTH(16)) dut (
        .clk       (clk),
        .reset     (rst_n),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] data, input logic stop_bit);
        bus.rx = 1'b0;
        idle(16);
        for (int i = 0; i < 8; i++) begin
            bus.rx = data[i];
            idle(16);
        end
        bus.rx = stop_bit;
        idle(16);
        bus.rx = 1'b1;
        idle(32);
    endtask

    task automatic pop_byte();
        bus.rd_en = 1'b1;
        @(negedge clk);
        bus.rd_en = 1'b0;
    endtask

    task automatic pop_check(input string name);
        logic [7:0] e;
        pop_byte();
        if (exp_q.size() == 0) begin
            check({name, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(name, bus.d_out, e);
        end
    endtask

    initial begin
        int lat;
        int n;
        bus.rx    = 1'b1;
        bus.rd_en = 1'b0;

        vecs[0] = '{8'hA5, 1'b1, 1'b1};
        vecs[1] = '{8'h3C, 1'b0, BAD_STOP_KEPT};
        vecs[2] = '{8'h7E, 1'b1, 1'b1};
        vecs[3] = '{8'h00, 1'b1, 1'b1};
        vecs[4] = '{8'hFF, 1'b1, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1};
        vecs[6] = '{8'h01, 1'b1, 1'b1};
        for (int i = 7; i < 10; i++)
            vecs[i] = '{8'($urandom_range(0, 255)), 1'b1, 1'b1};

        // Reset state
        idle(3);
        check("reset_rx_empty", bus.rx_empty, 1);
        check("reset_d_out", bus.d_out, 8'h00);
        check("reset_state", fsm_state, ST_IDLE);
        rst_n = 1'b1;
        idle(4);

        // Table of frames: good, bad-stop, edge values and random bytes
        for (int i = 0; i < 10; i++) begin
            send_byte(vecs[i].data, vecs[i].stop);
            if (vecs[i].stored) begin
                exp_q.push_back(vecs[i].data);
                check("vec_nonempty", bus.rx_empty, 0);
                pop_check("vec_data");
                check("vec_empty_after_pop", bus.rx_empty, 1);
            end else begin
                check("vec_discarded", bus.rx_empty, 1);
            end
        end

        // Receive latency of A5 measured from the start edge
        lat = 0;
        exp_q.push_back(8'hA5);
        fork
            send_byte(8'hA5, 1'b1);
            begin
                while (bus.rx_empty && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        check("latency_in_range", (lat >= 150 && lat <= 162), 1);
        pop_check("latency_data");
        check("latency_empty", bus.rx_empty, 1);

        // Overflow: 17 bytes into a 16-deep FIFO, last one dropped
        for (int b = 1; b <= 17; b++) begin
            send_byte(8'(b), 1'b1);
            if (b <= 16) exp_q.push_back(8'(b));
        end
        check("full_nonempty", bus.rx_empty, 0);
        for (int i = 0; i < 16; i++) pop_check("overflow_order");
        check("overflow_drained", bus.rx_empty, 1);
        pop_byte();
        check("pop_empty_holds", bus.d_out, 8'h10);

        // Short low glitch is a false start
        bus.rx = 1'b0;
        idle(4);
        bus.rx = 1'b1;
        idle(200);
        check("glitch_empty", bus.rx_empty, 1);
        check("glitch_idle", fsm_state, ST_IDLE);

        // Reset in the middle of a frame
        bus.rx = 1'b0;
        idle(16);
        bus.rx = 1'b1;
        idle(32);
        bus.rx = 1'b0;
        idle(10);
        rst_n = 1'b0;
        idle(2);
        check("midreset_empty", bus.rx_empty, 1);
        check("midreset_d_out", bus.d_out, 8'h00);
        bus.rx = 1'b1;
        rst_n = 1'b1;
        idle(300);
        check("midreset_no_partial", bus.rx_empty, 1);
        check("midreset_idle", fsm_state, ST_IDLE);

        // Pop coinciding with PUSH on a one-entry FIFO
        send_byte(8'h33, 1'b1);
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h55);
        fork
            send_byte(8'h55, 1'b1);
            begin
                n = 0;
                while (fsm_state != ST_PUSH && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 400) check("coincide_push_timeout", 32'd0, 32'd1);
                pop_check("coincide_pop_old");
            end
        join
        check("coincide_nonempty", bus.rx_empty, 0);
        pop_check("coincide_new");
        check("coincide_empty", bus.rx_empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
